membus_arbiter: RTL and testbench

Two-requester arbiter that shares one Membus slave port, normally the core-side port of the MMIO controller, between the instruction-fetch master (m0) and the load/store master (m1).
- Grants one request at a time with round-robin priority.
- Tracks the single outstanding transaction and routes its response (rvalid/rdata) back to the owning master.
- Supports back-to-back issue: a new grant may be made in the same cycle the previous response returns.

---
 rtl/membus_arbiter.sv | 138 +++++++++++++
 tb/tb_membus_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter.sv
// Round-robin arbiter sharing one Membus slave port between fetch (m0) and load/store (m1).
// One outstanding transaction; request and response paths are combinational, only arbitration state is registered.
module membus_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_valid,
    output logic                    m0_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic                    m0_wen,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wmask,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic                    m1_valid,
    output logic                    m1_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic                    m1_wen,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wmask,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    s_valid,
    input  logic                    s_ready,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic                    s_wen,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wmask,
    input  logic                    s_rvalid,
    input  logic [DATA_WIDTH-1:0]   s_rdata
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic pending_r, owner_r, last_grant_r, locked_r, lock_id_r;
    logic can_issue_s, grant_s, grant_id_s, sel_valid_s, hs_s, rsp_s;

    // Grant selection inside the issue window; a held (locked) grant never switches.
    always_comb begin
        can_issue_s = !pending_r || s_rvalid;
        grant_s     = 1'b0;
        grant_id_s  = 1'b0;
        if (can_issue_s) begin
            if (locked_r) begin
                grant_s    = 1'b1;
                grant_id_s = lock_id_r;
            end else if (m0_valid && m1_valid) begin
                grant_s    = 1'b1;
                grant_id_s = !last_grant_r;
            end else if (m0_valid || m1_valid) begin
                grant_s    = 1'b1;
                grant_id_s = m1_valid;
            end else begin
                grant_s    = 1'b0;
                grant_id_s = 1'b0;
            end
        end else begin
            grant_s    = 1'b0;
            grant_id_s = 1'b0;
        end
        sel_valid_s = grant_s && (grant_id_s ? m1_valid : m0_valid);
        hs_s        = sel_valid_s && s_ready;
        rsp_s       = s_rvalid && pending_r;
    end

    // Request forwarding and ready steering; everything is forced low while in reset.
    always_comb begin
        s_valid  = 1'b0;
        s_addr   = {ADDR_WIDTH{1'b0}};
        s_wen    = 1'b0;
        s_wdata  = {DATA_WIDTH{1'b0}};
        s_wmask  = {MASK_WIDTH{1'b0}};
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        if (rst && grant_s) begin
            s_valid = sel_valid_s;
            if (grant_id_s) begin
                s_addr   = m1_addr;
                s_wen    = m1_wen;
                s_wdata  = m1_wdata;
                s_wmask  = m1_wmask;
                m1_ready = s_ready;
            end else begin
                s_addr   = m0_addr;
                s_wen    = m0_wen;
                s_wdata  = m0_wdata;
                s_wmask  = m0_wmask;
                m0_ready = s_ready;
            end
        end else begin
            s_valid = 1'b0;
        end
    end

    // Response routing to the owner of the outstanding transaction; spurious responses are dropped.
    always_comb begin
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = {DATA_WIDTH{1'b0}};
        m1_rdata  = {DATA_WIDTH{1'b0}};
        if (rst && pending_r) begin
            if (owner_r) begin
                m1_rvalid = rsp_s;
                m1_rdata  = s_rdata;
            end else begin
                m0_rvalid = rsp_s;
                m0_rdata  = s_rdata;
            end
        end else begin
            m0_rvalid = 1'b0;
        end
    end

    // Arbitration state: outstanding tracking, round-robin history and held-grant lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r    <= 1'b0;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            locked_r     <= 1'b0;
            lock_id_r    <= 1'b0;
        end else if (hs_s) begin
            pending_r    <= 1'b1;
            owner_r      <= grant_id_s;
            last_grant_r <= grant_id_s;
            locked_r     <= 1'b0;
        end else begin
            if (rsp_s) begin
                pending_r <= 1'b0;
            end
            if (sel_valid_s) begin
                locked_r  <= 1'b1;
                lock_id_r <= grant_id_s;
            end
        end
    end
endmodule

// File: tb/tb_membus_arbiter.sv
// Directed self-checking bench for membus_arbiter; inputs change 1 ns after posedge, outputs sampled 3 ns later.
module tb_membus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m0_ready, m0_wen, m0_rvalid;
    logic [63:0] m0_addr, m0_wdata, m0_rdata;
    logic [7:0]  m0_wmask;
    logic        m1_valid, m1_ready, m1_wen, m1_rvalid;
    logic [63:0] m1_addr, m1_wdata, m1_rdata;
    logic [7:0]  m1_wmask;
    logic        s_valid, s_ready, s_wen, s_rvalid;
    logic [63:0] s_addr, s_wdata, s_rdata;
    logic [7:0]  s_wmask;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] A0 = 64'h0000_0000_0000_1000;
    localparam logic [63:0] A1 = 64'h0000_0000_0000_2000;

    membus_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wen(m0_wen),
        .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wen(m1_wen),
        .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wen(s_wen),
        .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_addr = A0; m0_wen = 1'b0; m0_wdata = 64'h0; m0_wmask = 8'h00;
        m1_valid = 1'b0; m1_addr = A1; m1_wen = 1'b0; m1_wdata = 64'h0; m1_wmask = 8'h00;
        s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = 64'h0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        next_cycle();
        rst = 1'b1;
    endtask

    initial begin
        logic       g;
        logic       own;
        logic [63:0] exp_d;
        rst = 1'b0;
        idle_inputs();
        next_cycle();
        // Reset: outputs forced low even with live inputs.
        m0_valid = 1'b1; s_ready = 1'b1; s_rvalid = 1'b1; s_rdata = 64'h55;
        settle();
        chk("rst_s_valid", 64'(s_valid), 64'h0);
        chk("rst_m0_ready", 64'(m0_ready), 64'h0);
        chk("rst_m0_rvalid", 64'(m0_rvalid), 64'h0);
        chk("rst_s_addr", s_addr, 64'h0);
        idle_inputs();
        rst = 1'b1;
        next_cycle();

        // Single master m1 read.
        m1_valid = 1'b1; m1_addr = 64'h0000_0000_8000_0010; s_ready = 1'b1;
        settle();
        chk("single_m1_ready", 64'(m1_ready), 64'h1);
        chk("single_s_addr", s_addr, 64'h0000_0000_8000_0010);
        chk("single_m0_ready", 64'(m0_ready), 64'h0);
        next_cycle();
        m1_valid = 1'b0; m1_addr = A1; s_ready = 1'b0;
        settle();
        chk("single_c1_m1_rvalid", 64'(m1_rvalid), 64'h0);
        chk("single_c1_m0_rvalid", 64'(m0_rvalid), 64'h0);
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 64'h0000_0000_DEAD_BEEF;
        settle();
        chk("single_c2_m1_rvalid", 64'(m1_rvalid), 64'h1);
        chk("single_c2_m1_rdata", m1_rdata, 64'h0000_0000_DEAD_BEEF);
        chk("single_c2_m0_rvalid", 64'(m0_rvalid), 64'h0);
        next_cycle();
        idle_inputs();

        // Tie after reset: grants alternate m0, m1, m0, m1 with one-cycle responses.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            g = i[0];
            own = ~i[0];
            m0_valid = (i < 4); m1_valid = (i < 4); s_ready = 1'b1;
            s_rvalid = (i >= 1);
            exp_d = (own ? A1 : A0) + 64'h1111;
            s_rdata = (i >= 1) ? exp_d : 64'h0;
            settle();
            if (i < 4) begin
                chk($sformatf("tie%0d_s_addr", i), s_addr, g ? A1 : A0);
                chk($sformatf("tie%0d_m0_ready", i), 64'(m0_ready), 64'(!g));
                chk($sformatf("tie%0d_m1_ready", i), 64'(m1_ready), 64'(g));
            end
            if (i >= 1) begin
                chk($sformatf("tie%0d_m0_rvalid", i), 64'(m0_rvalid), 64'(!own));
                chk($sformatf("tie%0d_m1_rvalid", i), 64'(m1_rvalid), 64'(own));
                chk($sformatf("tie%0d_rdata", i), own ? m1_rdata : m0_rdata, exp_d);
            end
            next_cycle();
        end
        idle_inputs();

        // Lock: m1 held with s_ready low while m0 joins; m1 goes first, then m0.
        do_reset();
        m1_valid = 1'b1;
        settle();
        chk("lock_c0_s_addr", s_addr, A1);
        next_cycle();
        m0_valid = 1'b1;
        for (int i = 1; i < 3; i++) begin
            settle();
            chk($sformatf("lock_c%0d_s_addr", i), s_addr, A1);
            chk($sformatf("lock_c%0d_m0_ready", i), 64'(m0_ready), 64'h0);
            next_cycle();
        end
        s_ready = 1'b1;
        settle();
        chk("lock_c3_s_addr", s_addr, A1);
        chk("lock_c3_m1_ready", 64'(m1_ready), 64'h1);
        chk("lock_c3_m0_ready", 64'(m0_ready), 64'h0);
        next_cycle();
        m1_valid = 1'b0; s_rvalid = 1'b1; s_rdata = 64'hAAAA;
        settle();
        chk("lock_c4_m1_rvalid", 64'(m1_rvalid), 64'h1);
        chk("lock_c4_m0_ready", 64'(m0_ready), 64'h1);
        chk("lock_c4_s_addr", s_addr, A0);
        next_cycle();
        m0_valid = 1'b0; s_rdata = 64'hBBBB;
        settle();
        chk("lock_c5_m0_rvalid", 64'(m0_rvalid), 64'h1);
        chk("lock_c5_m0_rdata", m0_rdata, 64'hBBBB);
        next_cycle();
        idle_inputs();

        // Back-to-back: m0 write outstanding, response retires as m1 is accepted.
        m0_valid = 1'b1; m0_wen = 1'b1; m0_wdata = 64'h0123_4567_89AB_CDEF; m0_wmask = 8'h0F;
        s_ready = 1'b1;
        settle();
        chk("b2b_m0_ready", 64'(m0_ready), 64'h1);
        chk("b2b_s_wen", 64'(s_wen), 64'h1);
        chk("b2b_s_wdata", s_wdata, 64'h0123_4567_89AB_CDEF);
        chk("b2b_s_wmask", 64'(s_wmask), 64'h0F);
        next_cycle();
        m0_valid = 1'b0; m0_wen = 1'b0; m1_valid = 1'b1; s_rvalid = 1'b1; s_rdata = 64'hC0DE;
        settle();
        chk("b2b_ret_m0_rvalid", 64'(m0_rvalid), 64'h1);
        chk("b2b_ret_m0_rdata", m0_rdata, 64'hC0DE);
        chk("b2b_m1_ready", 64'(m1_ready), 64'h1);
        chk("b2b_s_addr", s_addr, A1);
        next_cycle();
        m1_valid = 1'b0; s_rdata = 64'hF00D;
        settle();
        chk("b2b_own_m1_rvalid", 64'(m1_rvalid), 64'h1);
        chk("b2b_own_m0_rvalid", 64'(m0_rvalid), 64'h0);
        chk("b2b_own_m1_rdata", m1_rdata, 64'hF00D);
        next_cycle();
        idle_inputs();

        // Spurious response while idle; round-robin history must be untouched (last was m1).
        s_rvalid = 1'b1; s_rdata = 64'h5A5A;
        settle();
        chk("spur_m0_rvalid", 64'(m0_rvalid), 64'h0);
        chk("spur_m1_rvalid", 64'(m1_rvalid), 64'h0);
        next_cycle();
        s_rvalid = 1'b0; m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1;
        settle();
        chk("spur_tie_s_addr", s_addr, A0);
        next_cycle();
        idle_inputs();

        // Reset mid-transaction: the late response is dropped, next m0 request works.
        rst = 1'b0;
        settle();
        chk("midrst_s_valid", 64'(s_valid), 64'h0);
        next_cycle();
        rst = 1'b1;
        s_rvalid = 1'b1; s_rdata = 64'h7777;
        settle();
        chk("midrst_m0_rvalid", 64'(m0_rvalid), 64'h0);
        chk("midrst_m1_rvalid", 64'(m1_rvalid), 64'h0);
        next_cycle();
        s_rvalid = 1'b0; m0_valid = 1'b1; s_ready = 1'b1;
        settle();
        chk("midrst_m0_ready", 64'(m0_ready), 64'h1);
        chk("midrst_s_addr", s_addr, A0);
        next_cycle();
        m0_valid = 1'b0; s_rvalid = 1'b1; s_rdata = 64'h8888;
        settle();
        chk("midrst_resp_m0_rvalid", 64'(m0_rvalid), 64'h1);
        chk("midrst_resp_m0_rdata", m0_rdata, 64'h8888);
        next_cycle();
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
